// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl_if
//  Description : Bundle between the decode stage and the hazard/stall
//                sequencer. Carries decode's register usage, the EX branch
//                result, the memory stall, and the returned pipeline controls.
//  Ports       : master - decode/EX/memory side; drives dec_*, br_taken,
//                         mem_stall, cnt_clr and receives the controls
//                slave  - sequencer side; the mirror image
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic [4:0]  dec_rd;
    logic        dec_en_reg_wr;
    logic        dec_is_load;
    logic        br_taken;
    logic        mem_stall;
    logic        cnt_clr;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [15:0] stall_count;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_rd, dec_en_reg_wr, dec_is_load, br_taken, mem_stall, cnt_clr,
        input  stall, bubble, flush, stall_count
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               dec_rd, dec_en_reg_wr, dec_is_load, br_taken, mem_stall, cnt_clr,
        output stall, bubble, flush, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Decode-stage pipeline sequencer. Keeps a shift-register
//                scoreboard of in-flight register writes (EX..WB), detects
//                read-after-write hazards against decode's source registers,
//                and produces the fetch/decode stall, the EX bubble and the
//                branch flush. Also keeps a saturating hazard-stall counter.
//  Ports       : clk  - clock
//                rst  - synchronous reset, active high
//                bus  - hazard_stall_ctrl_if.slave (decode inputs, branch,
//                       memory stall, counter clear; stall/bubble/flush/count)
//  Parameters  : DEPTH     - scoreboard slots between decode and writeback
//                FWD_EN    - 1: only load-use in EX stalls; 0: any match stalls
//                FLUSH_LEN - flush cycles after a taken branch (1..7)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int DEPTH     = 3,
    parameter int FWD_EN    = 0,
    parameter int FLUSH_LEN = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_stall_ctrl_if.slave bus
);

    localparam logic [2:0]  C_FLUSH_RELOAD = 3'(FLUSH_LEN - 1);
    localparam logic [15:0] C_CNT_MAX      = 16'hFFFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Slot 0 is the instruction currently in EX; higher slots are older.
    logic [DEPTH-1:0]      r_sb_v;
    logic [DEPTH-1:0][4:0] r_sb_rd;
    // Only EX's load flag is ever consulted: once a load has left EX its
    // data is available to the forwarding network, so older slots need no
    // load marker.
    logic                  r_sb0_ld;
    logic [2:0]            r_flush_cnt;
    logic [15:0]           r_stall_count;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic             w_rs1_live;
    logic             w_rs2_live;
    logic [DEPTH-1:0] w_slot_match;
    logic             w_match_any;
    logic             w_match_load0;
    logic             w_hazard_src;
    logic             w_flush;
    logic             w_hazard;
    logic             w_bubble;
    logic             w_sb0_v;

    // x0 is hardwired to zero, so reading it can never depend on a producer.
    assign w_rs1_live = bus.dec_use_rs1 & (bus.dec_rs1 != 5'd0);
    assign w_rs2_live = bus.dec_use_rs2 & (bus.dec_rs2 != 5'd0);

    always_comb begin
        w_slot_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_match[i] = r_sb_v[i] &
                              ((w_rs1_live & (r_sb_rd[i] == bus.dec_rs1)) |
                               (w_rs2_live & (r_sb_rd[i] == bus.dec_rs2)));
        end
    end

    assign w_match_any   = |w_slot_match;
    assign w_match_load0 = w_slot_match[0] & r_sb0_ld;

    // With forwarding only a load in EX cannot supply its result in time.
    assign w_hazard_src = (FWD_EN != 0) ? w_match_load0 : w_match_any;

    // A taken branch flushes in the same cycle it resolves, then the counter
    // keeps the flush up for the remaining FLUSH_LEN-1 cycles.
    assign w_flush = (r_flush_cnt != 3'd0) | bus.br_taken;

    // Decode being squashed by a flush wins over any hazard it might carry.
    assign w_hazard = bus.dec_valid & ~w_flush & w_hazard_src;

    // While memory freezes the pipe, EX keeps its instruction, so no NOP.
    assign w_bubble = (w_hazard | w_flush) & ~bus.mem_stall;

    // A squashed or x0-writing instruction never occupies a valid slot.
    assign w_sb0_v = bus.dec_valid & bus.dec_en_reg_wr &
                     (bus.dec_rd != 5'd0) & ~w_bubble;

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_v        <= '0;
            r_sb_rd       <= '0;
            r_sb0_ld      <= 1'b0;
            r_flush_cnt   <= 3'd0;
            r_stall_count <= 16'd0;
        end else if (!bus.mem_stall) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_sb_v[i]  <= r_sb_v[i-1];
                r_sb_rd[i] <= r_sb_rd[i-1];
            end
            r_sb_v[0]  <= w_sb0_v;
            r_sb_rd[0] <= bus.dec_rd;
            r_sb0_ld   <= bus.dec_is_load;

            // A new branch during an active flush restarts the window.
            if (bus.br_taken) begin
                r_flush_cnt <= C_FLUSH_RELOAD;
            end else if (r_flush_cnt != 3'd0) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end

            if (bus.cnt_clr) begin
                r_stall_count <= 16'd0;
            end else if (w_hazard && (r_stall_count != C_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (forced quiet while reset is asserted)
    // ------------------------------------------------------------------
    assign bus.stall       = ~rst & (w_hazard | bus.mem_stall);
    assign bus.bubble      = ~rst & w_bubble;
    assign bus.flush       = ~rst & w_flush;
    assign bus.stall_count = r_stall_count;

endmodule
`default_nettype wire
